// File: rtl/ahb_button_events.sv
// ahb_button_events
//   AHB-Lite slave turning the debounced, active-low Mode/Trip button levels
//   into discrete events (short press, long press, two-button chord), queued
//   in a small FIFO that firmware reads through a four-word register map.
//
//   Configuration macro: CHORD_DETECT_EN
//     defined   : a simultaneous press of both buttons yields one CHORD event
//                 and suppresses both buttons until they are released.
//     undefined : the buttons are fully independent; CHORD is never produced.
//
//   Ports
//     HCLK, HRESETn      clock, asynchronous active-low reset
//     debounced_nMode    Mode button level, 0 = pressed
//     debounced_nTrip    Trip button level, 0 = pressed
//     HSEL..HWDATA       AHB-Lite slave inputs (HADDR[3:2] decoded only)
//     HRDATA             read data, data phase
//     HREADYOUT, HRESP   always ready / OKAY
//     IRQ                registered interrupt: IE & FIFO not empty
//
//   Register map (HADDR[3:2])
//     0 EVENT  RO  [2:0] head code; a read of a non-empty FIFO pops it
//     1 STATUS     [4:0] count, [8] OVF (write 1 clears), [9] Mode pressed,
//                  [10] Trip pressed
//     2 CTRL   RW  [0] IE
//     3        reads 0
module ahb_button_events #(
    parameter int unsigned LONG_CYCLES = 33200,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        debounced_nMode,
    input  logic        debounced_nTrip,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        IRQ
);

    localparam int unsigned CW = $clog2(LONG_CYCLES + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG, ST_SUPP} btn_state_t;
    typedef enum logic [2:0] {
        EV_NONE       = 3'd0,
        EV_MODE_SHORT = 3'd1,
        EV_MODE_LONG  = 3'd2,
        EV_TRIP_SHORT = 3'd3,
        EV_TRIP_LONG  = 3'd4,
        EV_CHORD      = 3'd5
    } ev_t;

    // index 0 = Mode, index 1 = Trip
    btn_state_t      r_state [2];
    logic [CW-1:0]   r_cnt   [2];
    logic [1:0]      w_pressed;
    logic [1:0]      w_short;
    logic [1:0]      w_long;
    logic            w_chord;
    logic [2:0]      w_ev_mode;
    logic [2:0]      w_ev_trip;

    logic            r_dp_valid;
    logic            r_dp_write;
    logic [1:0]      r_dp_addr;
    logic            w_dp_act;
    logic            w_pop;
    logic            w_ovf_clr;
    logic            w_ie_wr;

    logic [2:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [NW-1:0]   r_count;
    logic            r_ovf;
    logic            r_ie;
    logic [NW-1:0]   w_free;
    logic            w_want_m;
    logic            w_want_t;
    logic            w_acc_m;
    logic            w_acc_t;
    logic            w_ovf_set;
    logic [31:0]     w_status;
    logic            w_unused;

    assign w_pressed = {~debounced_nTrip, ~debounced_nMode};
    assign w_unused  = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:9],
                         HWDATA[7:1], HTRANS[0]};

    always_comb begin
        w_short = '0;
        w_long  = '0;
        for (int unsigned b = 0; b < 2; b++) begin
            w_short[b] = (r_state[b] == ST_HELD) & ~w_pressed[b];
            w_long[b]  = (r_state[b] == ST_HELD) & w_pressed[b] &
                         (r_cnt[b] + CW'(1) == CW'(LONG_CYCLES));
        end
    end

`ifdef CHORD_DETECT_EN
    assign w_chord = (&w_pressed) &
                     (r_state[0] inside {ST_IDLE, ST_HELD}) &
                     (r_state[1] inside {ST_IDLE, ST_HELD});
`else
    assign w_chord = 1'b0;
`endif

    // A chord outranks any short/long decided on the same edge.
    always_comb begin
        w_ev_mode = EV_NONE;
        w_ev_trip = EV_NONE;
        if (w_chord) begin
            w_ev_mode = EV_CHORD;
        end else begin
            if (w_short[0])     w_ev_mode = EV_MODE_SHORT;
            else if (w_long[0]) w_ev_mode = EV_MODE_LONG;
            if (w_short[1])     w_ev_trip = EV_TRIP_SHORT;
            else if (w_long[1]) w_ev_trip = EV_TRIP_LONG;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int unsigned b = 0; b < 2; b++) begin
                r_state[b] <= ST_IDLE;
                r_cnt[b]   <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                case (r_state[b])
                    ST_IDLE: begin
                        if (w_chord) begin
                            r_state[b] <= ST_SUPP;
                        end else if (w_pressed[b]) begin
                            r_state[b] <= ST_HELD;
                            r_cnt[b]   <= CW'(1);
                        end
                    end
                    ST_HELD: begin
                        if (w_chord) begin
                            r_state[b] <= ST_SUPP;
                            r_cnt[b]   <= '0;
                        end else if (!w_pressed[b]) begin
                            r_state[b] <= ST_IDLE;
                            r_cnt[b]   <= '0;
                        end else begin
                            r_cnt[b] <= r_cnt[b] + CW'(1);
                            if (w_long[b]) r_state[b] <= ST_LONG;
                        end
                    end
                    ST_LONG: begin
                        if (!w_pressed[b]) begin
                            r_state[b] <= ST_IDLE;
                            r_cnt[b]   <= '0;
                        end
                    end
                    ST_SUPP: begin
                        if (!w_pressed[b]) r_state[b] <= ST_IDLE;
                    end
                    default: r_state[b] <= ST_IDLE;
                endcase
            end
        end
    end

    // AHB address phase capture; the data phase completes when HREADY is high.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= '0;
        end else if (HREADY) begin
            r_dp_valid <= HSEL & HTRANS[1];
            r_dp_write <= HWRITE;
            r_dp_addr  <= HADDR[3:2];
        end
    end

    assign w_dp_act  = r_dp_valid & HREADY;
    assign w_pop     = w_dp_act & ~r_dp_write & (r_dp_addr == 2'd0) &
                       (r_count != '0);
    assign w_ovf_clr = w_dp_act & r_dp_write & (r_dp_addr == 2'd1) & HWDATA[8];
    assign w_ie_wr   = w_dp_act & r_dp_write & (r_dp_addr == 2'd2);

    // A pop frees its slot for a push on the same edge; Mode is placed first.
    always_comb begin
        w_free    = NW'(FIFO_DEPTH) - r_count + NW'(w_pop);
        w_want_m  = (w_ev_mode != 3'd0);
        w_want_t  = (w_ev_trip != 3'd0);
        w_acc_m   = w_want_m & (w_free != '0);
        w_acc_t   = w_want_t & (w_free > (w_acc_m ? NW'(1) : NW'(0)));
        w_ovf_set = (w_want_m & ~w_acc_m) | (w_want_t & ~w_acc_t);
    end

    always_ff @(posedge HCLK) begin
        if (w_acc_m) r_mem[r_wr_ptr] <= w_ev_mode;
        if (w_acc_t) r_mem[r_wr_ptr + AW'(w_acc_m)] <= w_ev_trip;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_ie     <= 1'b0;
            IRQ      <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_acc_m) + AW'(w_acc_t);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + NW'(w_acc_m) + NW'(w_acc_t) - NW'(w_pop);
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
            if (w_ie_wr) r_ie <= HWDATA[0];
            IRQ <= r_ie & (r_count != '0);
        end
    end

    always_comb begin
        w_status       = '0;
        w_status[4:0]  = 5'(r_count);
        w_status[8]    = r_ovf;
        w_status[9]    = w_pressed[0];
        w_status[10]   = w_pressed[1];
        HRDATA         = '0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_addr)
                2'd0: if (r_count != '0) HRDATA[2:0] = r_mem[r_rd_ptr];
                2'd1: HRDATA = w_status;
                2'd2: HRDATA[0] = r_ie;
                default: HRDATA = '0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_button_events.sv
// Testbench for ahb_button_events (LONG_CYCLES=20, FIFO_DEPTH=4).
// A duration-based button/FIFO model predicts every read; predictions are
// queued when the data phase begins and a monitor compares them on the
// falling edge. Directed reads also carry a hand-derived constant.
module tb_ahb_button_events;

    localparam int LC = 20;
    localparam int FD = 4;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        nMode   = 1'b1;
    logic        nTrip   = 1'b1;
    logic        HSEL    = 1'b0;
    logic [31:0] HADDR   = '0;
    logic [1:0]  HTRANS  = '0;
    logic        HWRITE  = 1'b0;
    logic [2:0]  HSIZE   = 3'b010;
    logic        HREADY  = 1'b1;
    logic [31:0] HWDATA  = '0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        IRQ;

    ahb_button_events #(.LONG_CYCLES(LC), .FIFO_DEPTH(FD)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .debounced_nMode(nMode), .debounced_nTrip(nTrip),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] model;
        bit          has_c;
        logic [31:0] c;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;

    // reference model state
    int          m_held [2];
    bit          m_long [2];
    bit          m_sup  [2];
    logic [2:0]  fq[$];
    bit          m_ovf, m_ie, m_irq, irq_vis;
    bit          m_dpv, m_dpw, m_dpc;
    logic [1:0]  m_dpa;
    logic [31:0] m_dpk;
    bit          tb_chas = 1'b0;
    logic [31:0] tb_cexp = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int b = 0; b < 2; b++) begin
            m_held[b] = 0; m_long[b] = 0; m_sup[b] = 0;
        end
        fq.delete();
        sb.delete();
        m_ovf = 0; m_ie = 0; m_irq = 0; irq_vis = 0;
        m_dpv = 0; m_dpw = 0; m_dpc = 0; m_dpa = 0; m_dpk = 0;
    endtask

    // Effect of the coming rising edge given the levels currently driven.
    task automatic model_edge();
        bit   p [2];
        int   ev[$];
        bit   chord;
        bit   irq_n;
        exp_t e;
        p[0] = !nMode;
        p[1] = !nTrip;
        irq_n = m_ie && (fq.size() != 0);
        if (m_dpv) begin
            if (!m_dpw) begin
                e.model = '0;
                case (m_dpa)
                    2'd0: if (fq.size() > 0) e.model = 32'(fq[0]);
                    2'd1: e.model = (32'(p[1]) << 10) | (32'(p[0]) << 9) |
                                    (32'(m_ovf) << 8) | 32'(fq.size());
                    2'd2: e.model = 32'(m_ie);
                    default: e.model = '0;
                endcase
                e.has_c = m_dpc;
                e.c     = m_dpk;
                sb.push_back(e);
                if (m_dpa == 2'd0 && fq.size() > 0) void'(fq.pop_front());
            end else begin
                if (m_dpa == 2'd1 && HWDATA[8]) m_ovf = 0;
                if (m_dpa == 2'd2) m_ie = HWDATA[0];
            end
        end
`ifdef CHORD_DETECT_EN
        chord = p[0] && p[1] && !m_long[0] && !m_sup[0] && !m_long[1] && !m_sup[1];
`else
        chord = 0;
`endif
        if (chord) begin
            ev.push_back(5);
            for (int b = 0; b < 2; b++) begin
                m_sup[b] = 1; m_held[b] = 0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (p[b]) begin
                    if (!m_long[b] && !m_sup[b]) begin
                        m_held[b]++;
                        if (m_held[b] == LC) begin
                            ev.push_back(b == 0 ? 2 : 4);
                            m_long[b] = 1;
                        end
                    end
                end else begin
                    if (m_held[b] > 0 && !m_long[b] && !m_sup[b])
                        ev.push_back(b == 0 ? 1 : 3);
                    m_held[b] = 0; m_long[b] = 0; m_sup[b] = 0;
                end
            end
        end
        foreach (ev[i]) begin
            if (fq.size() < FD) fq.push_back(3'(ev[i]));
            else m_ovf = 1;
        end
        m_irq = irq_n;
        m_dpv = HSEL && HTRANS[1] && HREADY;
        m_dpw = HWRITE;
        m_dpa = HADDR[3:2];
        m_dpc = tb_chas;
        m_dpk = tb_cexp;
    endtask

    always @(negedge HCLK) begin
        if (HRESETn) begin
            chk("irq", {31'b0, IRQ}, {31'b0, irq_vis});
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("rdata", HRDATA, mon_e.model);
                if (mon_e.has_c) chk("rdata_dir", HRDATA, mon_e.c);
            end
        end
    end

    task automatic cycle();
        model_edge();
        @(posedge HCLK);
        irq_vis = m_irq;
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
            cycle();
        end
    endtask

    task automatic set_addr(int a);
        HADDR = ($urandom() & 32'hFFFF_FFF3) | (32'(a) << 2);
    endtask

    task automatic rd_issue(int a, bit hc, logic [31:0] c);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; set_addr(a);
        tb_chas = hc; tb_cexp = c;
        cycle();
        HSEL = 0; HTRANS = 2'b00; tb_chas = 0;
    endtask

    task automatic rd_chk(int a, logic [31:0] c);
        rd_issue(a, 1, c);
        idle(1);
    endtask

    task automatic wr(int a, logic [31:0] d);
        HSEL = 1; HTRANS = 2'b11; HWRITE = 1; set_addr(a);
        cycle();
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
        cycle();
    endtask

    task automatic press(int b, int n);
        if (b == 0) nMode = 0; else nTrip = 0;
        idle(n);
        nMode = 1; nTrip = 1;
        idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rd_w;
        int r;
        reset_model();
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1;

        // reset state
        rd_chk(1, 32'h0);
        rd_chk(2, 32'h0);
        rd_chk(0, 32'h0);

        // Mode short press
        nMode = 0; idle(5); nMode = 1; idle(1);
        rd_chk(1, 32'h1);
        rd_chk(0, 32'h1);
        rd_chk(1, 32'h0);

        // Trip long press: LONG appears on the 20th pressed sample
        nTrip = 0; idle(17);
        rd_chk(1, 32'h400);
        rd_chk(1, 32'h401);
        idle(9); nTrip = 1; idle(1);
        rd_chk(1, 32'h1);
        rd_chk(0, 32'h4);
        rd_chk(1, 32'h0);

        // staggered press, common release
        nMode = 0; idle(3); nTrip = 0; idle(2); nMode = 1; nTrip = 1; idle(1);
`ifdef CHORD_DETECT_EN
        rd_chk(1, 32'h1);
        rd_chk(0, 32'h5);
`else
        rd_chk(1, 32'h2);
        rd_chk(0, 32'h1);
        rd_chk(0, 32'h3);
`endif
        rd_chk(1, 32'h0);

        // simultaneous press and release
        nMode = 0; nTrip = 0; idle(4); nMode = 1; nTrip = 1; idle(1);
`ifdef CHORD_DETECT_EN
        rd_chk(0, 32'h5);
`else
        rd_chk(0, 32'h1);
        rd_chk(0, 32'h3);
`endif
        rd_chk(1, 32'h0);

        // overflow and clear
        press(0, 2); press(1, 2); press(0, 2); press(1, 2); press(0, 2);
        rd_chk(1, 32'h104);
        wr(1, 32'h100);
        rd_chk(1, 32'h4);
        rd_chk(0, 32'h1);
        rd_chk(0, 32'h3);
        rd_chk(0, 32'h1);
        rd_chk(0, 32'h3);
        rd_chk(0, 32'h0);
        rd_chk(1, 32'h0);

        // pop and push on the same edge while full
        press(0, 2); press(1, 2); press(0, 2); press(1, 2);
        nMode = 0; idle(2);
        rd_issue(0, 1, 32'h1);
        nMode = 1; idle(1);
        rd_chk(1, 32'h4);

        // overflow set beats a clear on the same edge
        nTrip = 0; idle(2);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; set_addr(1);
        cycle();
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = 32'h100; nTrip = 1;
        cycle();
        rd_chk(1, 32'h104);
        rd_chk(0, 32'h3);
        rd_chk(0, 32'h1);
        rd_chk(0, 32'h3);
        rd_chk(0, 32'h1);
        rd_chk(1, 32'h100);
        wr(1, 32'h100);
        rd_chk(1, 32'h0);

        // interrupt
        press(1, 3);
        wr(2, 32'h1);
        idle(2);
        chk("irq_set", {31'b0, IRQ}, 32'h1);
        rd_issue(0, 1, 32'h3);
        idle(1);
        chk("irq_hold", {31'b0, IRQ}, 32'h1);
        idle(1);
        chk("irq_clr", {31'b0, IRQ}, 32'h0);

        // reset mid-hold during a data phase
        press(1, 3);
        idle(2);
        chk("irq_pre_rst", {31'b0, IRQ}, 32'h1);
        nMode = 0; idle(5);
        rd_issue(2, 1, 32'h1);
        HRESETn = 0;
        reset_model();
        #1;
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_irq", {31'b0, IRQ}, 32'h0);
        chk("rst_hready", {31'b0, HREADYOUT}, 32'h1);
        chk("rst_hresp", {31'b0, HRESP}, 32'h0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1;
        rd_chk(1, 32'h200);
        rd_chk(2, 32'h0);
        idle(3); nMode = 1; idle(1);
        rd_chk(0, 32'h1);
        rd_chk(1, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) nMode = ~nMode;
            if ($urandom_range(0, 15) == 0) nTrip = ~nTrip;
            rd_w = (i < 1500) ? 1 : 8;
            r = $urandom_range(0, 39);
            if (r < rd_w) begin
                rd_issue($urandom_range(0, 3), 0, 32'h0);
            end else if (r < rd_w + 2) begin
                wr($urandom_range(0, 3), $urandom());
            end else if (r == 39) begin
                HSEL = 1; HTRANS = 2'b01; HWRITE = 1'($urandom_range(0, 1));
                set_addr($urandom_range(0, 3));
                cycle();
                HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
            end else if (r == 38) begin
                HSEL = 0; HTRANS = 2'b10; HWRITE = 0; set_addr(0);
                cycle();
                HTRANS = 2'b00;
            end else begin
                idle(1);
            end
        end
        nMode = 1; nTrip = 1;
        idle(2);
        rd_issue(1, 0, 32'h0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_button_events.md
# ahb_button_events

AHB-Lite slave that consumes the debounced, active-low nMode/nTrip button levels and turns them into discrete user events: short press, long press and two-button chord. Events are queued in a small FIFO and read by the processor, with an optional interrupt. The block sits between the button debouncer and the cycle-computer firmware; its register map replaces direct polling of button levels.

## Interface
- LONG_CYCLES, 33200: consecutive pressed samples that make a long press (about 1 s at 33.2 kHz); legal range 2..65535.
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..16.
- HCLK  in  1  system clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- debounced_nMode  in  1  Mode button level; 0 = pressed; synchronous to HCLK.
- debounced_nTrip  in  1  Trip button level; 0 = pressed; synchronous to HCLK.
- HSEL  in  1  slave select.
- HADDR  in  32  address; only [3:2] decoded.
- HTRANS  in  2  transfer type; transfer valid when HTRANS[1]=1.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  ignored; word access assumed.
- HREADY  in  1  bus ready; address phase sampled only when 1.
- HWDATA  in  32  write data, data phase.
- HRDATA  out  32  read data, data phase; reset 0.
- HREADYOUT  out  1  constant 1 (zero wait states).
- HRESP  out  1  constant 0 (OKAY).
- IRQ  out  1  registered interrupt; reset 0.

## Operation
- Event codes (3 bits): 0 NONE, 1 MODE_SHORT, 2 MODE_LONG, 3 TRIP_SHORT, 4 TRIP_LONG, 5 CHORD.
- Per-button FSM (Mode, Trip identical), counter width clog2(LONG_CYCLES+1):
  - IDLE: pressed sample -> HELD, cnt<=1.
  - HELD: released -> IDLE, push SHORT. Pressed -> cnt<=cnt+1; if cnt+1==LONG_CYCLES -> LONG, push LONG.
  - LONG: released -> IDLE, no event.
  - SUPP: released -> IDLE, no event.
- Chord: both buttons pressed in the same sample and neither FSM in LONG/SUPP -> push CHORD, both FSMs -> SUPP. Chord takes priority over any SHORT/LONG from the same edge. Once one button is LONG, the other button runs independently.
- A button still held when reset is released counts as a fresh press on the first sample.
- FIFO: accepts up to 2 pushes per edge; when both occur, the Mode event is written first, then Trip. A push with no free slot is dropped and sets sticky OVF. Free slots = FIFO_DEPTH - count + (pop this edge), so a pop and a push on the same edge while full are both accepted.
- Registers (HADDR[3:2]):
  - 0 EVENT (RO): [2:0] head code, other bits 0. A valid read pops one entry. Reading an empty FIFO returns 0 and does not pop. Writes ignored.
  - 1 STATUS: [4:0] count, [8] OVF, [9] Mode pressed, [10] Trip pressed. Writing HWDATA[8]=1 clears OVF; if an overflow occurs on the same edge, the set wins.
  - 2 CTRL (RW): [0] IE, reset 0.
  - 3: reads 0, writes ignored.
- IRQ <= IE & (count != 0).

## Timing
- Address phase registered when HSEL & HTRANS[1] & HREADY. HRDATA is driven in the data phase from the current register/head value. The pop, or the write update from HWDATA, happens at the edge that ends the data phase.
- Event push happens at the edge that samples the deciding level. The count is visible to an address phase issued in the next cycle.
- Short press: the release is sampled k edges after the press (1 <= k <= LONG_CYCLES-1).
- LONG is pushed on the LONG_CYCLES-th consecutive pressed sample.
- IRQ follows count/IE changes by one cycle.
- Reset (async, any time): all FSMs IDLE, counters 0, FIFO empty, OVF 0, IE 0, HRDATA 0, IRQ 0. Any pending data phase is abandoned.

## Configuration
- CHORD_DETECT_EN defined: chord logic and SUPP state present, as above.
- CHORD_DETECT_EN undefined: no chord detection and SUPP is unreachable. Buttons are fully independent, and code 5 is never produced.

## Test plan
All scenarios use LONG_CYCLES=20, FIFO_DEPTH=4.
- Mode pressed for 5 cycles, then released -> STATUS count=1; EVENT read returns 1; next STATUS count=0.
- Trip held for 30 cycles -> TRIP_LONG (4) pushed on the 20th pressed sample; release adds nothing; count=1.
- Mode pressed, Trip pressed 3 cycles later, both released -> single event 5. With CHORD_DETECT_EN undefined -> events 1 then 3.
- Both buttons released on the same edge from HELD (macro off) -> FIFO order 1, 3.
- 5 short presses with no reads -> count=4, OVF=1; write STATUS 0x100 -> OVF=0; four reads return the first four codes; a fifth read returns 0.
- IE=1 with one event queued -> IRQ=1. Read EVENT -> IRQ=0 one cycle after the pop. Assert HRESETn low mid-hold -> all outputs 0, count=0.
